// File: rtl/io_bus_pkg.sv
// Shared definitions for the IO bus master: bus addresses,
// status bit positions, combine-op and FSM state encodings.
package io_bus_pkg;

    localparam logic [1:0] ADDR_STATUS = 2'b00;
    localparam logic [1:0] ADDR_LED    = 2'b01;
    localparam logic [1:0] ADDR_SW_LO  = 2'b10;
    localparam logic [1:0] ADDR_SW_HI  = 2'b11;

    localparam int STAT_ACK = 0;
    localparam int STAT_RDY = 1;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_POLL_RDY,
        S_GAP_RDY,
        S_RD_LO,
        S_RD_HI,
        S_CALC,
        S_WR,
        S_POLL_ACK,
        S_GAP_ACK
    } state_e;

    function automatic logic is_poll(state_e s);
        return s inside {S_POLL_RDY, S_GAP_RDY, S_POLL_ACK, S_GAP_ACK};
    endfunction

    function automatic logic is_gap(state_e s);
        return s inside {S_GAP_RDY, S_GAP_ACK};
    endfunction

endpackage

// File: rtl/io_combine_alu.sv
// Combines the two switch bytes into the 12-bit LED value.
// Ports: i_lo/i_hi switch bytes, i_op combine op, o_res result.
module io_combine_alu
    import io_bus_pkg::*;
(
    input  logic [7:0]  i_lo,
    input  logic [7:0]  i_hi,
    input  op_e         i_op,
    output logic [11:0] o_res
);

    logic [11:0] w_lo;
    logic [11:0] w_hi;

    assign w_lo = {4'h0, i_lo};
    assign w_hi = {4'h0, i_hi};

    // Subtraction wraps modulo 4096 by construction of the 12-bit width.
    always_comb begin
        o_res = '0;
        unique case (i_op)
            OP_ADD:  o_res = w_lo + w_hi;
            OP_SUB:  o_res = w_lo - w_hi;
            OP_AND:  o_res = w_lo & w_hi;
            OP_XOR:  o_res = w_lo ^ w_hi;
            default: o_res = '0;
        endcase
    end

endmodule

// File: rtl/io_bus_master.sv
// CPU-less bus initiator for the switch/LED peripheral: polls status,
// reads both switch bytes, combines them, writes the LED, waits for ack.
// Ports: clk, reset (sync, active-high); start/op control; busy/done/
// result/error status; pread/pwrite/addr/pwritedata/preaddata bus.
// Optional macro IO_MASTER_TIMEOUT_EN bounds the poll loops by TIMEOUT.
module io_bus_master
    import io_bus_pkg::*;
#(
    parameter int unsigned POLL_GAP = 4,
    parameter int unsigned TIMEOUT  = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    output logic        busy,
    output logic        done,
    output logic [11:0] result,
    output logic        error,
    output logic        pread,
    output logic        pwrite,
    output logic [1:0]  addr,
    output logic [11:0] pwritedata,
    input  logic [31:0] preaddata
);

    // A gap state always lasts at least one cycle, so POLL_GAP=0
    // still yields one idle cycle between polls.
    localparam logic [7:0] GAP_LAST =
        (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);

    state_e      r_state;
    state_e      w_next;
    op_e         r_op;
    logic [7:0]  r_lo;
    logic [7:0]  r_hi;
    logic [7:0]  r_gap;
    logic [11:0] r_result;

    logic        r_busy;
    logic        r_done;
    logic        r_pread;
    logic        r_pwrite;
    logic [1:0]  r_addr;
    logic [11:0] r_wdata;

    logic        w_accept;
    logic        w_rdy;
    logic        w_ack;
    logic        w_in_poll;
    logic        w_gap_end;
    logic [11:0] w_alu;

    logic        w_busy_n;
    logic        w_done_n;
    logic        w_pread_n;
    logic        w_pwrite_n;
    logic [1:0]  w_addr_n;
    logic [11:0] w_wdata_n;

    logic        w_unused;

    assign w_accept  = (r_state == S_IDLE) && start;
    assign w_rdy     = preaddata[STAT_RDY];
    assign w_ack     = preaddata[STAT_ACK];
    assign w_in_poll = is_poll(r_state);
    assign w_gap_end = (r_gap == GAP_LAST);
    assign w_unused  = ^{preaddata[31:8], (TIMEOUT == 0)};

`ifdef IO_MASTER_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [TW-1:0] r_to_cnt;
    logic          r_error;
    logic          w_to_hit;
    logic          w_to_fire;

    // Counter reads 1 in the first poll cycle of each phase.
    assign w_to_hit = w_in_poll && (r_to_cnt == TW'(TIMEOUT - 1));
`endif

    io_combine_alu u_alu (
        .i_lo  (r_lo),
        .i_hi  (r_hi),
        .i_op  (r_op),
        .o_res (w_alu)
    );

    // State register plus registered bus/status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pread  <= 1'b0;
            r_pwrite <= 1'b0;
            r_addr   <= ADDR_STATUS;
            r_wdata  <= '0;
        end else begin
            r_state  <= w_next;
            r_busy   <= w_busy_n;
            r_done   <= w_done_n;
            r_pread  <= w_pread_n;
            r_pwrite <= w_pwrite_n;
            r_addr   <= w_addr_n;
            r_wdata  <= w_wdata_n;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
`ifdef IO_MASTER_TIMEOUT_EN
        w_to_fire = 1'b0;
`endif
        unique case (r_state)
            S_IDLE:     if (start) w_next = S_POLL_RDY;
            S_POLL_RDY: w_next = w_rdy ? S_RD_LO : S_GAP_RDY;
            S_GAP_RDY:  if (w_gap_end) w_next = S_POLL_RDY;
            S_RD_LO:    w_next = S_RD_HI;
            S_RD_HI:    w_next = S_CALC;
            S_CALC:     w_next = S_WR;
            S_WR:       w_next = S_POLL_ACK;
            S_POLL_ACK: w_next = w_ack ? S_IDLE : S_GAP_ACK;
            S_GAP_ACK:  if (w_gap_end) w_next = S_POLL_ACK;
            default:    w_next = S_IDLE;
        endcase
`ifdef IO_MASTER_TIMEOUT_EN
        // Progress out of the loop wins over a coincident timeout.
        if (w_to_hit && is_poll(w_next)) begin
            w_next    = S_IDLE;
            w_to_fire = 1'b1;
        end
`endif
    end

    // Output decode from the state being entered, so that the
    // registered strobes line up with the state that owns them.
    always_comb begin
        w_pread_n  = 1'b0;
        w_pwrite_n = 1'b0;
        w_addr_n   = ADDR_STATUS;
        w_wdata_n  = '0;
        unique case (w_next)
            S_POLL_RDY, S_POLL_ACK: begin
                w_pread_n = 1'b1;
                w_addr_n  = ADDR_STATUS;
            end
            S_RD_LO: begin
                w_pread_n = 1'b1;
                w_addr_n  = ADDR_SW_LO;
            end
            S_RD_HI: begin
                w_pread_n = 1'b1;
                w_addr_n  = ADDR_SW_HI;
            end
            S_WR: begin
                w_pwrite_n = 1'b1;
                w_addr_n   = ADDR_LED;
                w_wdata_n  = w_alu;
            end
            default: ;
        endcase
        w_busy_n = (w_next != S_IDLE);
        w_done_n = (r_state != S_IDLE) && (w_next == S_IDLE);
    end

    // Datapath: latched op, captured switch bytes, gap counter, result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= OP_ADD;
            r_lo     <= '0;
            r_hi     <= '0;
            r_gap    <= '0;
            r_result <= '0;
        end else begin
            if (w_accept)
                r_op <= op_e'(op);
            if (r_state == S_RD_LO)
                r_lo <= preaddata[7:0];
            if (r_state == S_RD_HI)
                r_hi <= preaddata[7:0];
            if (r_state == S_CALC)
                r_result <= w_alu;
            if (is_gap(r_state) && (w_next == r_state))
                r_gap <= r_gap + 8'd1;
            else
                r_gap <= '0;
        end
    end

`ifdef IO_MASTER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt <= '0;
            r_error  <= 1'b0;
        end else begin
            if (w_accept)
                r_error <= 1'b0;
            else if (w_to_fire)
                r_error <= 1'b1;
            if ((r_state == S_IDLE && w_next == S_POLL_RDY) ||
                (r_state == S_WR && w_next == S_POLL_ACK))
                r_to_cnt <= TW'(1);
            else if (w_in_poll)
                r_to_cnt <= r_to_cnt + TW'(1);
        end
    end

    assign error = r_error;
`else
    assign error = 1'b0;
`endif

    assign busy       = r_busy;
    assign done       = r_done;
    assign result     = r_result;
    assign pread      = r_pread;
    assign pwrite     = r_pwrite;
    assign addr       = r_addr;
    assign pwritedata = r_wdata;

endmodule

// File: tb/tb_io_bus_master.sv
// Randomised bench for io_bus_master: peripheral model plus a
// transaction schedule model compared against the DUT every cycle.
module tb_io_bus_master;
    import io_bus_pkg::*;

    localparam int unsigned PG = 4;
    localparam int unsigned TO = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic        busy;
    logic        done;
    logic [11:0] result;
    logic        error;
    logic        pread;
    logic        pwrite;
    logic [1:0]  addr;
    logic [11:0] pwritedata;
    logic [31:0] preaddata;

    always #5 clk = ~clk;

    io_bus_master #(.POLL_GAP(PG), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .error      (error),
        .pread      (pread),
        .pwrite     (pwrite),
        .addr       (addr),
        .pwritedata (pwritedata),
        .preaddata  (preaddata)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // ---------------- peripheral model ----------------
    logic [7:0]  sw_lo = 8'h00;
    logic [7:0]  sw_hi = 8'h00;
    logic [31:0] junk  = 32'h0;
    int cur_nr = 0;
    int cur_na = 0;
    int txn_id = 0;
    int seen_id = 0;
    int polls = 0;
    bit ph = 1'b0;

    always @(posedge clk) begin
        junk <= $urandom;
        if (txn_id != seen_id) begin
            seen_id <= txn_id;
            ph      <= 1'b0;
            polls   <= 0;
        end else if (pwrite) begin
            ph    <= 1'b1;
            polls <= 0;
        end else if (pread && addr == 2'b00) begin
            polls <= polls + 1;
        end
    end

    always_comb begin
        preaddata = junk;
        if (pread) begin
            case (addr)
                2'b00: begin
                    preaddata[1] = ph ? junk[1] : (polls >= cur_nr);
                    preaddata[0] = ph ? (polls >= cur_na) : junk[0];
                end
                2'b10:   preaddata[7:0] = sw_lo;
                2'b11:   preaddata[7:0] = sw_hi;
                default: ;
            endcase
        end
    end

    // ---------------- schedule model ----------------
    typedef struct packed {
        logic        pread;
        logic        pwrite;
        logic [1:0]  addr;
        logic [11:0] wdata;
        logic        busy;
        logic        done;
    } bus_t;

    bus_t        exp_at[int];
    logic [11:0] res_at[int];
    bit          chk_en = 1'b0;
    logic [11:0] m_result = 12'h0;

    function automatic logic [11:0] ref_combine(int o, int lo, int hi);
        case (o)
            0:       return 12'(lo + hi);
            1:       return 12'((lo - hi + 4096) % 4096);
            2:       return 12'(lo & hi);
            default: return 12'(lo ^ hi);
        endcase
    endfunction

    task automatic mark_read(input int c, input logic [1:0] a);
        bus_t t;
        t = exp_at[c];
        t.pread = 1'b1;
        t.addr  = a;
        exp_at[c] = t;
    endtask

    // Poll period is the poll cycle plus max(1, POLL_GAP) gap cycles.
    task automatic add_txn(input int s, input int o, input int lo,
                           input int hi, input int nr, input int na,
                           output int d);
        int g;
        int tr;
        bus_t t;
        logic [11:0] v;
        g  = ((PG == 0) ? 1 : int'(PG)) + 1;
        tr = s + 1 + nr * g;
        d  = tr + 5 + na * g + 1;
        v  = ref_combine(o, lo, hi);
        for (int c = s + 1; c < d; c++) begin
            t = '0;
            t.busy = 1'b1;
            exp_at[c] = t;
        end
        for (int k = 0; k <= nr; k++) mark_read(s + 1 + k * g, 2'b00);
        mark_read(tr + 1, 2'b10);
        mark_read(tr + 2, 2'b11);
        t = exp_at[tr + 4];
        t.pwrite = 1'b1;
        t.addr   = 2'b01;
        t.wdata  = v;
        exp_at[tr + 4] = t;
        res_at[tr + 4] = v;
        for (int k = 0; k <= na; k++) mark_read(tr + 5 + k * g, 2'b00);
        t = '0;
        t.done = 1'b1;
        exp_at[d] = t;
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bus_t e;
        bus_t a;
        if (chk_en) begin
            e = exp_at.exists(cyc) ? exp_at[cyc] : '0;
            if (res_at.exists(cyc)) m_result = res_at[cyc];
            a = {pread, pwrite, addr, pwritedata, busy, done};
            total++;
            if (a !== e || result !== m_result || error !== 1'b0) begin
                bad++;
                $display("FAIL cyc%0d bus: got pr=%b pw=%b a=%h wd=%h bz=%b dn=%b res=%h err=%b want pr=%b pw=%b a=%h wd=%h bz=%b dn=%b res=%h err=0",
                         cyc, pread, pwrite, addr, pwritedata, busy, done,
                         result, error, e.pread, e.pwrite, e.addr, e.wdata,
                         e.busy, e.done, m_result);
            end
        end
    end

    // ---------------- event monitors ----------------
    int last_done = -1;
    int n_done = 0;
    int n_stat = 0;
    int n_pread = 0;
    int n_pwrite = 0;

    always @(negedge clk) begin
        if (done) begin
            last_done = cyc;
            n_done++;
        end
        if (pread) n_pread++;
        if (pread && addr == 2'b00) n_stat++;
        if (pwrite) n_pwrite++;
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic run_txn(input int o, input logic [15:0] sw,
                           input int nr, input int na, input bit poke,
                           output int s, output int d);
        int g;
        @(negedge clk);
        sw_lo  = sw[7:0];
        sw_hi  = sw[15:8];
        cur_nr = nr;
        cur_na = na;
        txn_id++;
        s = cyc;
        add_txn(s, o, int'(sw[7:0]), int'(sw[15:8]), nr, na, d);
        start = 1'b1;
        op    = o[1:0];
        @(negedge clk);
        start = 1'b0;
        if (poke) begin
            @(negedge clk);
            start = 1'b1;
            op    = ~o[1:0];
            @(negedge clk);
            start = 1'b0;
        end
        g = 0;
        while (cyc < d && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) chk("txn_bound", 32'(cyc), 32'(d));
        @(negedge clk);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int d;
        int n0;
        int k;
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        repeat (3) @(negedge clk);
        chk("reset_state",
            32'({busy, done, result, error, pread, pwrite, addr, pwritedata}),
            32'h0);
        reset  = 1'b0;
        chk_en = 1'b1;

        run_txn(0, 16'h1234, 0, 0, 1'b0, s, d);
        chk("add_res", 32'(result), 32'h046);
        chk("add_lat", 32'(last_done - s), 32'd7);
        run_txn(1, 16'h0705, 0, 0, 1'b0, s, d);
        chk("sub_res", 32'(result), 32'hFFE);
        run_txn(2, 16'h3CF0, 0, 0, 1'b0, s, d);
        chk("and_res", 32'(result), 32'h030);
        run_txn(3, 16'h3CF0, 0, 0, 1'b0, s, d);
        chk("xor_res", 32'(result), 32'h0CC);

        n0 = n_stat;
        run_txn(0, 16'h0102, 3, 0, 1'b0, s, d);
        chk("poll_res", 32'(result), 32'h003);
        chk("poll_lat", 32'(last_done - s), 32'd22);
        chk("poll_cnt", 32'(n_stat - n0), 32'd5);

        n0 = n_done;
        run_txn(2, 16'hFF0F, 1, 1, 1'b1, s, d);
        chk("busy_start_res", 32'(result), 32'h00F);
        chk("busy_start_done", 32'(n_done - n0), 32'd1);

        repeat (40) begin
            run_txn(int'($urandom_range(0, 3)), 16'($urandom),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), s, d);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        chk_en = 1'b0;

`ifdef IO_MASTER_TIMEOUT_EN
        @(negedge clk);
        cur_nr = 100000;
        cur_na = 0;
        txn_id++;
        s = cyc;
        start = 1'b1;
        op    = 2'b00;
        @(negedge clk);
        start = 1'b0;
        while (cyc < s + TO) @(negedge clk);
        chk("to_done", 32'(done), 32'd1);
        chk("to_err", 32'(error), 32'd1);
        k = n_pread;
        repeat (10) @(negedge clk);
        chk("to_quiet", 32'(n_pread - k), 32'd0);
        chk("to_sticky", 32'(error), 32'd1);
        run_txn(0, 16'h0101, 0, 0, 1'b0, s, d);
        chk("to_clear", 32'(error), 32'd0);
        chk("to_next_res", 32'(result), 32'h002);
`endif

        @(negedge clk);
        sw_lo  = 8'h11;
        sw_hi  = 8'h22;
        cur_nr = 0;
        cur_na = 0;
        txn_id++;
        n0 = n_pwrite;
        s = cyc;
        start = 1'b1;
        op    = 2'b00;
        @(negedge clk);
        start = 1'b0;
        while (cyc < s + 4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_outs",
            32'({busy, done, result, error, pread, pwrite, addr, pwritedata}),
            32'h0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("rst_mid_nowrite", 32'(n_pwrite - n0), 32'd0);
        chk("rst_mid_idle", 32'({busy, pread}), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
